// File: rtl/tinsel_accel_pkg.sv
// Shared flit/address types and FSM state encoding for the accelerator message collector.
package tinsel_accel_pkg;

    typedef struct packed {
        logic       acc;
        logic       host;
        logic [2:0] board_y;
        logic [2:0] board_x;
        logic [1:0] mbox_y;
        logic [1:0] mbox_x;
        logic [5:0] thread;
    } NetAddr;

    typedef struct packed {
        NetAddr      dest;
        logic        not_final_flit;
        logic        is_idle_token;
        logic [31:0] payload;
    } Flit;

    localparam int FLIT_BITS = $bits(Flit);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DROP  = 1'b1
    } collect_state_e;

    function automatic logic is_final_flit(input Flit f);
        return !f.not_final_flit;
    endfunction

endpackage

// File: rtl/accel_flit_ram.sv
// Flit storage: one write port registered on the falling clock edge, one asynchronous read port.
module accel_flit_ram
    import tinsel_accel_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [FLIT_BITS-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [FLIT_BITS-1:0] rdata
);

    logic [FLIT_BITS-1:0] mem [DEPTH];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/accel_msg_collector.sv
// Store-and-forward collector between an accelerator's flit output and the mesh injection port.
// Optional counters stat_msgs/stat_drops exist only when ACCEL_COLLECT_STATS_EN is defined.
module accel_msg_collector
    import tinsel_accel_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int MAX_MSG_FLITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  Flit         in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output Flit         out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_oversize
`ifdef ACCEL_COLLECT_STATS_EN
    ,
    output logic [31:0] stat_msgs,
    output logic [31:0] stat_drops
`endif
);

    // Handshake: a flit moves on a port in any cycle where valid && ready at the falling edge;
    // ready and valid depend only on registered state, never combinationally on the other side.

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int LEN_W = $clog2(MAX_MSG_FLITS) + 1;

    localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_MSG_FLITS - 1);

    localparam logic [0:0] ST_ACCUM = 1'(ACCUM);
    localparam logic [0:0] ST_DROP  = 1'(DROP);

    logic [PTR_W-1:0]     wr;
    logic [PTR_W-1:0]     cm;
    logic [PTR_W-1:0]     rd;
    logic [LEN_W-1:0]     len;
    logic [0:0]           state;
    logic [PTR_W-1:0]     occupancy;
    logic                 in_fire;
    logic                 out_fire;
    logic                 final_flit;
    logic                 accum_fire;
    logic                 oversize;
    logic                 mem_we;
    logic [FLIT_BITS-1:0] ram_rdata;

    assign occupancy  = wr - rd;
    assign in_ready   = (state == ST_DROP) || (occupancy != FULL_OCC);
    assign out_valid  = (rd != cm);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign final_flit = is_final_flit(in_data);
    assign accum_fire = in_fire && (state == ST_ACCUM);

    // The flit that would exceed the limit is never written; the partial message is rolled back.
    assign oversize   = accum_fire && !final_flit && (len == LEN_LAST);
    assign mem_we     = accum_fire && !oversize;

    always_ff @(negedge clk) begin
        if (rst) begin
            wr           <= '0;
            cm           <= '0;
            rd           <= '0;
            len          <= '0;
            state        <= ST_ACCUM;
            err_oversize <= 1'b0;
        end else begin
            if (out_fire) begin
                rd <= rd + 1'b1;
            end
            if (state == ST_ACCUM) begin
                if (in_fire) begin
                    if (final_flit) begin
                        wr  <= wr + 1'b1;
                        cm  <= wr + 1'b1;
                        len <= '0;
                    end else if (len == LEN_LAST) begin
                        wr           <= cm;
                        len          <= '0;
                        err_oversize <= 1'b1;
                        state        <= ST_DROP;
                    end else begin
                        wr  <= wr + 1'b1;
                        len <= len + 1'b1;
                    end
                end
            end else begin
                // Swallow the tail of an oversize message up to and including its final flit.
                if (in_fire && final_flit) begin
                    state <= ST_ACCUM;
                end
            end
        end
    end

`ifdef ACCEL_COLLECT_STATS_EN
    always_ff @(negedge clk) begin
        if (rst) begin
            stat_msgs  <= '0;
            stat_drops <= '0;
        end else begin
            if (accum_fire && final_flit) begin
                stat_msgs <= stat_msgs + 1'b1;
            end
            if (oversize) begin
                stat_drops <= stat_drops + 1'b1;
            end
        end
    end
`endif

    accel_flit_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign out_data = ram_rdata;

endmodule

// File: doc/accel_msg_collector.md
Name: accel_msg_collector

Overview:
- Sits between an external accelerator's outgoing flit stream and the mailbox-mesh injection port. It is the receiver for the accelerator's transmit side.
- Buffers flits, forwarding a message only once its final flit has arrived (store-and-forward). A stalled or misbehaving accelerator therefore never leaves a partial message wedged in the NoC.
- Oversize messages are discarded and flagged.

Parameters:
- DEPTH, 16, flit buffer entries; power of 2, ≥ MAX_MSG_FLITS.
- MAX_MSG_FLITS, 4, maximum legal flits per message.

Ports:
- clk  in  1  clock; all state updates on negedge clk.
- rst  in  1  synchronous active-high reset, sampled on negedge clk.
- in_data  in  $bits(Flit)  flit from accelerator.
- in_valid  in  1  in_data valid.
- in_ready  out  1  collector accepts flit this cycle.
- out_data  out  $bits(Flit)  flit to mesh.
- out_valid  out  1  out_data valid.
- out_ready  in  1  mesh accepts flit.
- err_oversize  out  1  sticky; set on any oversize message, cleared only by rst.

Behaviour:
- Transfer rules:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
  - out_data is stable while out_valid && !out_ready.
- Pointers: circular buffer with three pointers, each log2(DEPTH)+1 bits and wrapping naturally.
  - wr: next write.
  - cm: commit boundary.
  - rd: next read.
- Derived signals:
  - Occupancy is wr-rd.
  - out_valid = (rd != cm).
  - out_data = mem[rd].
- Reset: wr=cm=rd=0, len=0, state=ACCUM, err_oversize=0. Therefore out_valid=0 and in_ready=1 one cycle after reset. Reset mid-message discards all buffered and partial flits.
- State ACCUM:
  - in_ready = (wr-rd) != DEPTH.
  - On input transfer: mem[wr] <= flit, wr <= wr+1.
  - If notFinalFlit==0: cm <= wr+1, len <= 0.
  - Else if len == MAX_MSG_FLITS-1: oversize handling (below).
  - Else: len <= len+1.
- Oversize handling: the flit is not written, wr <= cm, len <= 0, err_oversize <= 1, state <= DROP.
- State DROP:
  - in_ready=1; all accepted flits are discarded.
  - On an accepted flit with notFinalFlit==0: state <= ACCUM.
  - Committed flits keep draining normally.
- Latency: if the final flit is accepted at negedge N, the message's first flit is visible at out_valid after negedge N (cm registered). Flits then stream one per cycle while out_ready=1.
- Simultaneous events:
  - An input and an output transfer may occur in the same cycle.
  - A full buffer with a simultaneous read still deasserts in_ready, because in_ready is registered-state-based with no combinational in→out path.
  - A commit and a read in the same cycle are independent.
- Flit ordering is preserved. Idle-token flits (isIdleToken=1) are ordinary flits: buffered, committed and forwarded in order.
- Single-flit messages (notFinalFlit=0 on the first flit) commit immediately.
- Deadlock freedom: since MAX_MSG_FLITS ≤ DEPTH, a partial message always finds space once committed data drains.

Optional Feature:
- Macro: ACCEL_COLLECT_STATS_EN.
- Defined: adds two outputs, each 32-bit and wrapping, cleared by rst.
  - stat_msgs: increments on each commit.
  - stat_drops: increments on each oversize event.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package tinsel_accel_pkg holds:
  - the NetAddr and Flit packed typedefs;
  - the FLIT_BITS constant;
  - the state enum {ACCUM, DROP}.
- Sub-module accel_flit_ram: DEPTH×FLIT_BITS storage with one registered write port and one asynchronous read port. The collector holds pointers and the FSM.

Test Plan:
- Single flit, out_ready=1: flit accepted at negedge N → out_valid high after N with identical payload, out_valid low after N+1.
- Three-flit message with a 5-cycle gap before the final flit → out_valid stays 0 until the final flit is accepted, then three flits emerge back-to-back in order.
- Five non-final flits with MAX_MSG_FLITS=4 → err_oversize=1 on the 4th flit; flits 5..final are dropped; the next 2-flit message is forwarded intact; stat_drops=1 (stats build).
- out_ready=0, 16 single-flit messages → in_ready drops after 16; raise out_ready → 16 flits emerge in order and in_ready returns.
- Continuous in/out at full rate with pointer wrap (≥40 messages, random lengths 1–4) → scoreboard matches exactly with no bubbles once steady.
- rst asserted with a 2-flit partial message and 3 committed flits buffered → after reset out_valid=0, in_ready=1, and no stale flits appear later.
